// File: rtl/wildeq_scan_pkg.sv
// Shared types for the wildcard-equality scan engine: FSM states and the
// three-valued comparator result with its fixed encoding.
package wildeq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] WEQ_0_ENC = 2'b00;
  localparam logic [1:0] WEQ_1_ENC = 2'b01;
  localparam logic [1:0] WEQ_X_ENC = 2'b10;

  typedef enum logic [1:0] {
    WEQ_0 = WEQ_0_ENC,
    WEQ_1 = WEQ_1_ENC,
    WEQ_X = WEQ_X_ENC
  } weq_t;

  // A scan stops on anything that is not a definite zero.
  function automatic logic weq_stop(input weq_t r);
    return r != WEQ_0;
  endfunction

endpackage

// File: rtl/wildeq_scan_if.sv
// Bundles the table-config, key-request and result-response channels of
// wildeq_scan; master is the requester/config side, slave is the engine.
interface wildeq_scan_if #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  parameter int IDXW  = $clog2(DEPTH)
);
  logic             cfg_we;
  logic             cfg_ready;
  logic [IDXW-1:0]  cfg_idx;
  logic             cfg_en;
  logic [WIDTH-1:0] cfg_val;
  logic [WIDTH-1:0] cfg_care;

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_key;
  logic [WIDTH-1:0] req_unk;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_hit;
  logic             rsp_unk;
  logic [IDXW-1:0]  rsp_idx;

  logic             busy;

  modport master (
    output cfg_we, cfg_idx, cfg_en, cfg_val, cfg_care,
    output req_valid, req_key, req_unk, rsp_ready,
    input  cfg_ready, req_ready, rsp_valid, rsp_hit, rsp_unk, rsp_idx, busy
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_en, cfg_val, cfg_care,
    input  req_valid, req_key, req_unk, rsp_ready,
    output cfg_ready, req_ready, rsp_valid, rsp_hit, rsp_unk, rsp_idx, busy
  );
endinterface

// File: rtl/wildeq_scan_cmp.sv
// Combinational ==? evaluator for one table entry against a 4-state key
// (unk flags the X/Z key bits); care=0 bits are wildcards.
module wildeq_cmp
  import wildeq_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] key,
  input  logic [WIDTH-1:0] unk,
  input  logic [WIDTH-1:0] val,
  input  logic [WIDTH-1:0] care,
  input  logic             en,
  output weq_t             res
);
  logic known_miss;
  logic cared_unk;

  // A known mismatch dominates any unknown bit, exactly as ==? does.
  assign known_miss = |(care & ~unk & (key ^ val));
  assign cared_unk  = |(care & unk);

  always_comb begin
    res = WEQ_1;
    if (!en || known_miss) res = WEQ_0;
    else if (cared_unk)    res = WEQ_X;
  end
endmodule

// File: rtl/wildeq_scan.sv
// Priority-match engine: scans DEPTH flop-based pattern entries one per cycle
// through a single shared ==? comparator and reports the first 1/X entry.
module wildeq_scan
  import wildeq_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  wildeq_scan_if.slave  bus
);
  state_t state, state_nxt;

  logic [DEPTH-1:0]            tbl_en;
  logic [DEPTH-1:0][WIDTH-1:0] tbl_val;
  logic [DEPTH-1:0][WIDTH-1:0] tbl_care;

  logic [WIDTH-1:0] key_q;
  logic [WIDTH-1:0] unk_q;
  logic [IDXW-1:0]  ptr;
  logic             hit_q;
  logic             unk_res_q;
  logic [IDXW-1:0]  idx_q;

  weq_t res;
  logic last;
  logic req_fire;
  logic cfg_fire;
  logic rsp_fire;

  assign last     = (ptr == IDXW'(DEPTH - 1));
  assign req_fire = bus.req_valid && (state == IDLE);
  assign cfg_fire = bus.cfg_we    && (state == IDLE);
  assign rsp_fire = bus.rsp_ready && (state == RESP);

  wildeq_cmp #(.WIDTH(WIDTH)) u_cmp (
    .key  (key_q),
    .unk  (unk_q),
    .val  (tbl_val[ptr]),
    .care (tbl_care[ptr]),
    .en   (tbl_en[ptr]),
    .res  (res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = SCAN;
      SCAN:    if (weq_stop(res) || last) state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.cfg_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    bus.busy      = (state != IDLE);
    bus.rsp_hit   = hit_q;
    bus.rsp_unk   = unk_res_q;
    bus.rsp_idx   = idx_q;
  end

  // Table write lands at the same edge as a concurrent req handshake, so the
  // first scan cycle already reads the new entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tbl_en    <= '0;
      tbl_val   <= '0;
      tbl_care  <= '0;
      key_q     <= '0;
      unk_q     <= '0;
      ptr       <= '0;
      hit_q     <= 1'b0;
      unk_res_q <= 1'b0;
      idx_q     <= '0;
    end else begin
      if (cfg_fire) begin
        tbl_en[bus.cfg_idx]   <= bus.cfg_en;
        tbl_val[bus.cfg_idx]  <= bus.cfg_val;
        tbl_care[bus.cfg_idx] <= bus.cfg_care;
      end
      if (req_fire) begin
        key_q <= bus.req_key;
        unk_q <= bus.req_unk;
        ptr   <= '0;
      end else if (state == SCAN) begin
        if (weq_stop(res)) begin
          hit_q     <= (res == WEQ_1);
          unk_res_q <= (res == WEQ_X);
          idx_q     <= ptr;
        end else if (last) begin
          hit_q     <= 1'b0;
          unk_res_q <= 1'b0;
          idx_q     <= '0;
        end else begin
          ptr <= ptr + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/wildeq_scan.md
# wildeq_scan

Sequential priority-match engine built around a single shared wildcard-equality (`==?`) comparator. A pattern table holds DEPTH programmable entries, each a value plus a care mask; care bits of 0 act like X/Z wildcards on the right-hand side of `==?`. The block accepts 4-state keys over a valid/ready handshake and scans the table one entry per cycle, stopping at the first entry that evaluates to 1 or X. It sits between a lookup requester and the table configuration path.

## Interface
- WIDTH, 9, key/pattern width in bits
- DEPTH, 8, number of table entries (power of two, ≥2)
- IDXW, $clog2(DEPTH), entry index width

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- cfg_we  in  1  table write strobe
- cfg_ready  out  1  write accepted this cycle
- cfg_idx  in  IDXW  entry to write
- cfg_en  in  1  entry enable
- cfg_val  in  WIDTH  pattern value
- cfg_care  in  WIDTH  care mask (1 = compared, 0 = wildcard)
- req_valid  in  1  key offered
- req_ready  out  1  key accepted when valid&ready
- req_key  in  WIDTH  key value bits
- req_unk  in  WIDTH  key X/Z flags (1 = unknown bit)
- rsp_valid  out  1  result held
- rsp_ready  in  1  result consumed when valid&ready
- rsp_hit  out  1  first non-zero entry evaluated to 1
- rsp_unk  out  1  first non-zero entry evaluated to X
- rsp_idx  out  IDXW  index of that entry; 0 when no match
- busy  out  1  state ≠ IDLE

## Operation
- Per-entry result (`==?` semantics):
  - disabled entry → 0
  - any cared bit with req_unk=0 and key≠val → 0
  - else any cared bit with req_unk=1 → X
  - else → 1
- Unknown key bits under care=0 never affect the result.
- FSM states:
  - IDLE: req_ready=1, cfg_ready=1. On a req handshake, latch key/unk, set ptr=0, go to SCAN.
  - SCAN: evaluate entry[ptr]. On 1 or X, latch the result and ptr, go to RESP. On 0 with ptr=DEPTH-1, latch no-match, go to RESP. Otherwise ptr++.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
- Table writes are accepted only in IDLE; cfg_we outside IDLE is dropped with no effect.
- A table write and a req handshake in the same IDLE cycle: the write commits first, and the scan sees the new entry.
- rsp_* outputs are registered and stable while rsp_valid=1.
- The latched key is unaffected by req_* changes after acceptance.

## Timing
- Reset values: every entry's enable=0 (value and mask don't care), state=IDLE, req_ready=1, cfg_ready=1, rsp_valid=0, rsp_hit=0, rsp_unk=0, rsp_idx=0, busy=0.
- Handshake at cycle T: entry k is evaluated in cycle T+1+k. A stop at entry k gives rsp_valid=1 from T+2+k.
- No match: rsp_valid=1 from T+1+DEPTH.
- Response handshake at cycle R: req_ready=1 in R+1. There is no back-to-back overlap.
- rsp_ready held low: rsp_valid and the data hold indefinitely.
- rst_n=0 in any state: the next cycle returns to reset values. An in-flight request and its response are lost, and the table is cleared.
- Disabled entries still cost one scan cycle.

## Structure
- Package wildeq_pkg: `state_t` {IDLE, SCAN, RESP}, `weq_t` {WEQ_0, WEQ_1, WEQ_X}, and the `weq_t` encoding constants.
- Sub-module wildeq_cmp: a purely combinational comparator.
  - Inputs: key, unk, val, care, en.
  - Output: `weq_t`.
  - It is instantiated once and shared across all entries via the ptr mux.
- Table storage is flops, with no RAM inference required.

## Test plan
- Reset: assert rst_n=0 for 2 cycles → req_ready=1, cfg_ready=1, rsp_valid=0, busy=0; a key of 0 with all entries disabled → no-match at T+9.
- Program entry2 en=1, val=9'h1A5, care=9'h1F0, then key 9'h1A3, unk=0 → rsp_hit=1, rsp_unk=0, rsp_idx=2, rsp_valid at T+4.
- Same entry2, key 9'h1A3 with unk=9'h010 (a cared bit) → rsp_unk=1, rsp_hit=0, rsp_idx=2. Repeat with unk=9'h001 (a wildcard bit) → rsp_hit=1.
- Entry1 val=0, care=9'h1FF and entry5 val=9'h0FF, care=9'h1FF, key 9'h0FF → hit idx 5 at T+7. A cfg_we to entry1 during SCAN is dropped; verify by readback of scan behaviour.
- Backpressure: hold rsp_ready=0 for 3 cycles → outputs are stable and req_ready=0; then rsp_ready=1 → req_ready=1 the next cycle.
- Pulse rst_n=0 mid-SCAN (T+3) → next cycle IDLE, no rsp_valid, table cleared; a following key → no-match.
